// File: rtl/nios2_subsystem_onchip_mem_arbiter.sv
// Quota round-robin arbiter sharing the single-port on-chip RAM between the Nios II data master (m0)
// and the visualizer reader (m1). Define ONCHIP_ARB_LOCK_EN to add per-master lock inputs.
`timescale 1ns/1ps
module nios2_subsystem_onchip_mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int MEM_DEPTH = 51200,
    parameter int QUOTA     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [3:0]        m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [31:0]       m0_writedata,
    output logic              m0_waitrequest,
    output logic [31:0]       m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [3:0]        m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [31:0]       m1_writedata,
    output logic              m1_waitrequest,
    output logic [31:0]       m1_readdata,
    output logic              m1_readdatavalid,
`ifdef ONCHIP_ARB_LOCK_EN
    input  logic              m0_lock,
    input  logic              m1_lock,
`endif
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_OWN0, ST_OWN1} owner_e;

    localparam logic [3:0]      QUOTA_C = 4'(QUOTA);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(MEM_DEPTH);

    owner_e            owner_q, owner_d;
    logic              last_m0_q, last_m0_d;
    logic [3:0]        count_q, count_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_id_q, rd_id_d;
    logic              rd_oor_q, rd_oor_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              req0, req1, lock0, lock1, quota_hit;
    logic              grant0, grant1, issue, in_range;
    logic [ADDR_W-1:0] sel_addr;
    logic [3:0]        sel_be;
    logic [31:0]       sel_wdata;
    logic              sel_write;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

`ifdef ONCHIP_ARB_LOCK_EN
    assign lock0 = m0_lock;
    assign lock1 = m1_lock;
`else
    assign lock0 = 1'b0;
    assign lock1 = 1'b0;
`endif

    assign quota_hit = (count_q == QUOTA_C);

    // Grant is decided in the same cycle so a hand-over costs no bubble.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        grant0 = 1'b0;
        grant1 = 1'b0;
        case (owner_q)
            ST_OWN0: begin
                if (req0 && !(quota_hit && req1 && !lock0)) grant0 = 1'b1;
                else if (req1)                              grant1 = 1'b1;
            end
            ST_OWN1: begin
                if (req1 && !(quota_hit && req0 && !lock1)) grant1 = 1'b1;
                else if (req0)                              grant0 = 1'b1;
            end
            default: begin
                if (req0 && req1) begin
                    if (last_m0_q) grant1 = 1'b1;
                    else           grant0 = 1'b1;
                end else if (req0) begin
                    grant0 = 1'b1;
                end else if (req1) begin
                    grant1 = 1'b1;
                end
            end
        endcase
        if (reset) begin
            grant0 = 1'b0;
            grant1 = 1'b0;
        end
    end

    assign issue     = grant0 | grant1;
    assign sel_addr  = grant1 ? m1_address    : m0_address;
    assign sel_be    = grant1 ? m1_byteenable : m0_byteenable;
    assign sel_wdata = grant1 ? m1_writedata  : m0_writedata;
    assign sel_write = grant1 ? m1_write      : m0_write;
    assign in_range  = ({1'b0, sel_addr} < DEPTH_C);

    always_comb begin
        owner_d    = ST_IDLE;
        count_d    = 4'd0;
        last_m0_d  = last_m0_q;
        rd_valid_d = issue & ~sel_write;
        rd_id_d    = grant1;
        rd_oor_d   = ~in_range;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        if (grant0) begin
            owner_d   = ST_OWN0;
            last_m0_d = 1'b1;
            if (owner_q == ST_OWN0) count_d = quota_hit ? count_q : count_q + 4'd1;
            else                    count_d = 4'd1;
        end else if (grant1) begin
            owner_d   = ST_OWN1;
            last_m0_d = 1'b0;
            if (owner_q == ST_OWN1) count_d = quota_hit ? count_q : count_q + 4'd1;
            else                    count_d = 4'd1;
        end
        if (issue) begin
            addr_d  = sel_addr;
            be_d    = sel_be;
            wdata_d = sel_wdata;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking only, so every flop samples the pre-edge value of its peers.
        if (reset) begin
            owner_q    <= ST_IDLE;
            last_m0_q  <= 1'b0;
            count_q    <= 4'd0;
            rd_valid_q <= 1'b0;
            rd_id_q    <= 1'b0;
            rd_oor_q   <= 1'b0;
            addr_q     <= '0;
            be_q       <= 4'd0;
            wdata_q    <= 32'd0;
        end else begin
            owner_q    <= owner_d;
            last_m0_q  <= last_m0_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_id_q    <= rd_id_d;
            rd_oor_q   <= rd_oor_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
        end
    end

    assign m0_waitrequest   = ~grant0;
    assign m1_waitrequest   = ~grant1;
    assign m0_readdatavalid = ~reset & rd_valid_q & ~rd_id_q;
    assign m1_readdatavalid = ~reset & rd_valid_q &  rd_id_q;
    // Out-of-range reads return zero rather than whatever the RAM output holds.
    assign m0_readdata      = (m0_readdatavalid && !rd_oor_q) ? mem_readdata : 32'd0;
    assign m1_readdata      = (m1_readdatavalid && !rd_oor_q) ? mem_readdata : 32'd0;

    assign mem_clken      = issue;
    assign mem_chipselect = issue & in_range;
    assign mem_write      = issue & in_range & sel_write;
    assign mem_address    = reset ? '0    : (issue ? sel_addr  : addr_q);
    assign mem_byteenable = reset ? 4'd0  : (issue ? sel_be    : be_q);
    assign mem_writedata  = reset ? 32'd0 : (issue ? sel_wdata : wdata_q);

endmodule
